da_controller: RTL and testbench

DA_CONTROLLER -- requirements
Module: da_controller

---
 rtl/da_controller.sv | 139 +++++++++++++
 tb/tb_da_controller.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/da_controller.sv
// Distributed-arithmetic FIR controller.
// Keeps a delay line of NUM_LUT*LUT_AW samples and, for each accepted sample,
// walks the taps bit-serially (sign bit first) for DATA_W cycles. Each cycle it
// presents one bit-slice of the delay line as packed LUT addresses. It then
// pulses out_strobe once the datapath accumulator holds the finished result.
//
// Ports:
//   clk3        clock, rising edge
//   reset       synchronous, active-low reset
//   in_data     two's-complement input sample
//   in_valid    in_data valid
//   in_ready    a sample can be accepted this cycle
//   flush       clear the delay line (honoured only while idle)
//   lut_addr    packed LUT addresses, LUT j on bits [LUT_AW*j +: LUT_AW]
//   addr_valid  lut_addr carries a live bit-slice
//   acc_clear   accumulator loads the LUT sum without shifted feedback
//   acc_neg     accumulator subtracts this slice (sign-bit weight)
//   out_strobe  one-cycle pulse, accumulator holds a finished output
//   primed      delay line has been filled since reset/flush
//   busy        controller is not idle
module da_controller #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned NUM_LUT = 8,
    parameter int unsigned LUT_AW  = 4
) (
    input  logic                      clk3,
    input  logic                      reset,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      flush,
    output logic [NUM_LUT*LUT_AW-1:0] lut_addr,
    output logic                      addr_valid,
    output logic                      acc_clear,
    output logic                      acc_neg,
    output logic                      out_strobe,
    output logic                      primed,
    output logic                      busy
);

    localparam int unsigned TAPS  = NUM_LUT * LUT_AW;
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned CNT_W = $clog2(TAPS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [BIT_W-1:0]   bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  tap_q [TAPS];
    logic [DATA_W-1:0]  tap_d [TAPS];

    // State, delay line and sample counter registers
    always_ff @(posedge clk3) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            cnt_q     <= '0;
            for (int i = 0; i < int'(TAPS); i++) begin
                tap_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            cnt_q     <= cnt_d;
            tap_q     <= tap_d;
        end
    end

    // Next-state and output decode; outputs depend only on registered state,
    // except in_ready which also reflects flush and reset directly.
    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        cnt_d      = cnt_q;
        tap_d      = tap_q;
        in_ready   = 1'b0;
        lut_addr   = '0;
        addr_valid = 1'b0;
        acc_clear  = 1'b0;
        acc_neg    = 1'b0;
        out_strobe = 1'b0;
        busy       = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = reset & ~flush;
                if (flush) begin
                    for (int i = 0; i < int'(TAPS); i++) begin
                        tap_d[i] = '0;
                    end
                    cnt_d = '0;
                end else if (in_valid) begin
                    for (int i = int'(TAPS) - 1; i > 0; i--) begin
                        tap_d[i] = tap_q[i-1];
                    end
                    tap_d[0]  = in_data;
                    bit_idx_d = BIT_W'(DATA_W - 1);
                    if (cnt_q != CNT_W'(TAPS)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    state_d = RUN;
                end
            end
            RUN: begin
                busy       = 1'b1;
                addr_valid = 1'b1;
                for (int k = 0; k < int'(TAPS); k++) begin
                    lut_addr[k] = tap_q[k][bit_idx_q];
                end
                // Sign slice comes first and restarts the accumulation
                if (bit_idx_q == BIT_W'(DATA_W - 1)) begin
                    acc_clear = 1'b1;
                    acc_neg   = 1'b1;
                end
                if (bit_idx_q == '0) begin
                    state_d = DONE;
                end else begin
                    bit_idx_d = bit_idx_q - BIT_W'(1);
                end
            end
            DONE: begin
                busy       = 1'b1;
                out_strobe = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign primed = (cnt_q == CNT_W'(TAPS));

endmodule

// File: tb/tb_da_controller.sv
// Bench for da_controller: directed scenarios plus random traffic, every cycle
// compared against a timeline model (phase counter since accept, sample array).
module tb_da_controller;

    localparam int DW   = 16;
    localparam int TAPS = 32;

    logic              clk3 = 1'b0;
    logic              reset;
    logic [DW-1:0]     in_data;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [TAPS-1:0]   lut_addr;
    logic              addr_valid;
    logic              acc_clear;
    logic              acc_neg;
    logic              out_strobe;
    logic              primed;
    logic              busy;

    always #5 clk3 = ~clk3;

    da_controller dut (
        .clk3       (clk3),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .lut_addr   (lut_addr),
        .addr_valid (addr_valid),
        .acc_clear  (acc_clear),
        .acc_neg    (acc_neg),
        .out_strobe (out_strobe),
        .primed     (primed),
        .busy       (busy)
    );

    // Model: phase 0 = idle, 1..16 = serial cycles (MSB first), 17 = result ready
    int          phase;
    int          mcount;
    logic [15:0] mtap [TAPS];
    int          npass;
    int          nfail;
    int          ntotal;
    logic [15:0] second_sample;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] slice(input int b);
        logic [31:0] r;
        for (int k = 0; k < TAPS; k++) r[k] = (mtap[k] >> b) & 16'd1;
        return r;
    endfunction

    // One clock cycle: drive, optionally compare, clock, advance the model
    task automatic cyc(input logic v, input logic [15:0] d, input logic f,
                       input logic r, input bit chk);
        logic run;
        in_valid = v;
        in_data  = d;
        flush    = f;
        reset    = r;
        #1;
        if (chk) begin
            run = (phase >= 1 && phase <= 16);
            check("busy",       32'(busy),       32'(phase != 0));
            check("in_ready",   32'(in_ready),   32'(r && phase == 0 && !f));
            check("addr_valid", 32'(addr_valid), 32'(run));
            check("lut_addr",   lut_addr,        run ? slice(16 - phase) : 32'h0);
            check("acc_clear",  32'(acc_clear),  32'(phase == 1));
            check("acc_neg",    32'(acc_neg),    32'(phase == 1));
            check("out_strobe", 32'(out_strobe), 32'(phase == 17));
            check("primed",     32'(primed),     32'(mcount >= 32));
        end
        @(posedge clk3);
        if (!r) begin
            phase  = 0;
            mcount = 0;
            for (int i = 0; i < TAPS; i++) mtap[i] = '0;
        end else if (phase == 0) begin
            if (f) begin
                mcount = 0;
                for (int i = 0; i < TAPS; i++) mtap[i] = '0;
            end else if (v) begin
                for (int i = TAPS - 1; i > 0; i--) mtap[i] = mtap[i-1];
                mtap[0] = d;
                if (mcount < 32) mcount++;
                phase = 1;
            end
        end else if (phase == 17) begin
            phase = 0;
        end else begin
            phase++;
        end
        @(negedge clk3);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        npass  = 0;
        nfail  = 0;
        ntotal = 0;
        phase  = 0;
        mcount = 0;
        for (int i = 0; i < TAPS; i++) mtap[i] = '0;

        // Reset: first edge establishes state, then outputs held low
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h1234, 1'b0, 1'b0, 1'b1);
        idle(1);

        // Lone sign bit: only tap[0] bit 0 in the sign slice
        cyc(1'b1, 16'h8000, 1'b0, 1'b1, 1'b1);
        #1;
        check("sign_lut", lut_addr, 32'h0000_0001);
        check("sign_clr", 32'(acc_clear), 32'd1);
        check("sign_neg", 32'(acc_neg), 32'd1);
        idle(16);
        #1;
        check("sign_strobe_c17", 32'(out_strobe), 32'd1);
        idle(2);

        // Two small samples; second pass shows both taps only in LSB slice
        cyc(1'b1, 16'h0001, 1'b0, 1'b1, 1'b1);
        idle(17);
        cyc(1'b1, 16'h0003, 1'b0, 1'b1, 1'b1);
        idle(15);
        #1;
        check("pair_lsb_lut", lut_addr, 32'h0000_0003);
        idle(3);

        // Flush with valid while idle: no accept, delay line cleared
        cyc(1'b1, 16'hABCD, 1'b1, 1'b1, 1'b1);
        #1;
        check("flush_primed", 32'(primed), 32'd0);
        idle(1);

        // Continuous valid: 33 accepts, one every 18 cycles
        for (int n = 0; n < 33 * 18; n++) begin
            logic [15:0] d;
            d = 16'($urandom);
            if (phase == 0 && n / 18 == 1) second_sample = d;
            cyc(1'b1, d, 1'b0, 1'b1, 1'b1);
        end
        #1;
        check("cont_primed", 32'(primed), 32'd1);
        check("cont_tap31", 32'(mtap[31]), 32'(second_sample));
        idle(18);

        // All-ones sample alone after flush; flush during the pass is ignored
        cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 17; i++) begin
            #1;
            if (i < 16) check("ones_lut", lut_addr, 32'h0000_0001);
            cyc(1'b0, 16'h0, (i % 3) == 1, 1'b1, 1'b1);
        end
        idle(1);

        // Reset while bit 7 is on the bus: pass abandoned, no strobe
        cyc(1'b1, 16'h5A5A, 1'b0, 1'b1, 1'b1);
        idle(8);
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 10; i++) begin
            #1;
            check("rst_no_strobe", 32'(out_strobe), 32'd0);
            cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
        end

        // Random traffic including occasional flush and reset
        for (int n = 0; n < 1500; n++) begin
            cyc(($urandom % 3) != 0, 16'($urandom), ($urandom % 16) == 0,
                ($urandom % 200) != 0, 1'b1);
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
